// File: rtl/display_arbiter.sv
// display_arbiter: round-robin time-sharing of the seven-segment/LED display path between four
// requesters. Each grant is held for at least DWELL_CYCLES so a value stays human-readable.
//
// Optional feature macro: DISP_ARB_PREEMPT_EN
//   When defined, a rising req[3] (error requester) seizes the display at the next edge, and
//   req[3] wins every arbitration. Requester 3 itself is never preempted.
//
// Parameters
//   DWELL_CYCLES : minimum grant duration in clk cycles (>= 2)
//   IDLE_DATA    : data_display value while no grant is active
// Ports
//   clk          : system clock, rising-edge
//   rst_n        : asynchronous active-low reset
//   req[3:0]     : level request per requester (bit 3 = error)
//   data_in[95:0]: requester i value at data_in[24*i +: 24]
//   led_in[63:0] : requester i LEDs at led_in[16*i +: 16]
//   blink_in[3:0]: requester i blink request
//   grant[3:0]   : registered one-hot grant, zero when idle
//   data_display, led_display, blink_need : registered outputs to the display driver
module display_arbiter #(
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter logic [23:0] IDLE_DATA    = 24'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [95:0] data_in,
  input  logic [63:0] led_in,
  input  logic [3:0]  blink_in,
  output logic [3:0]  grant,
  output logic [23:0] data_display,
  output logic [15:0] led_display,
  output logic        blink_need
);

  localparam int unsigned CntW = $clog2(DWELL_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShow, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      grant_q, grant_d;
  logic [23:0]     data_q, data_d;
  logic [15:0]     led_q, led_d;
  logic            blink_q, blink_d;

  logic            expired;
  logic            preempt_hit;
  logic            do_grant, do_copy, go_idle;
  logic [3:0]      pick_set;
  logic [1:0]      win;

  // Round-robin search starting after `last`, wrapping 3 -> 0. Iterating from the farthest
  // candidate to the nearest lets the nearest pending requester overwrite the result.
  function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] res;
    res = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (pend[idx]) res = idx;
    end
`ifdef DISP_ARB_PREEMPT_EN
    if (pend[3]) res = 2'd3;
`endif
    return res;
  endfunction

`ifdef DISP_ARB_PREEMPT_EN
  logic req3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req3_q <= 1'b0;
    else        req3_q <= req[3];
  end

  // Only a rising error request preempts, and only when someone else owns the display.
  assign preempt_hit = req[3] & ~req3_q & (last_q != 2'd3) & (state_q != StIdle);
`else
  assign preempt_hit = 1'b0;
`endif

  assign expired = (cnt_q == CntMax);

  always_comb begin
    state_d  = state_q;
    cnt_d    = expired ? cnt_q : cnt_q + 1'b1;
    last_d   = last_q;
    grant_d  = grant_q;
    data_d   = data_q;
    led_d    = led_q;
    blink_d  = blink_q;
    do_grant = 1'b0;
    do_copy  = 1'b0;
    go_idle  = 1'b0;
    pick_set = '0;

    case (state_q)
      StIdle: begin
        if (|req) begin
          do_grant = 1'b1;
          pick_set = req;
        end else begin
          go_idle = 1'b1;
        end
      end
      StShow: begin
        if (preempt_hit) begin
          do_grant = 1'b1;
          pick_set = 4'b1000;
        end else if (expired) begin
          if (|(req & ~grant_q)) begin
            do_grant = 1'b1;
            pick_set = req & ~grant_q;
          end else if (req[last_q]) begin
            do_copy = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end else if (!req[last_q]) begin
          state_d = StHold;  // outputs keep their last values
        end else begin
          do_copy = 1'b1;
        end
      end
      StHold: begin
        if (preempt_hit) begin
          do_grant = 1'b1;
          pick_set = 4'b1000;
        end else if (expired) begin
          // The frozen owner re-requesting counts as pending and competes normally.
          if (|req) begin
            do_grant = 1'b1;
            pick_set = req;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    win = rr_pick(pick_set, last_q);

    if (go_idle) begin
      state_d = StIdle;
      cnt_d   = '0;
      grant_d = '0;
      data_d  = IDLE_DATA;
      led_d   = '0;
      blink_d = 1'b0;
    end

    // The owner of an active grant is always last_q.
    if (do_copy) begin
      data_d  = data_in[24*last_q +: 24];
      led_d   = led_in[16*last_q +: 16];
      blink_d = blink_in[last_q];
    end

    if (do_grant) begin
      state_d = StShow;
      cnt_d   = '0;
      last_d  = win;
      grant_d = 4'b0001 << win;
      data_d  = data_in[24*win +: 24];
      led_d   = led_in[16*win +: 16];
      blink_d = blink_in[win];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      grant_q <= '0;
      data_q  <= IDLE_DATA;
      led_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      led_q   <= led_d;
      blink_q <= blink_d;
    end
  end

  assign grant        = grant_q;
  assign data_display = data_q;
  assign led_display  = led_q;
  assign blink_need   = blink_q;

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Time-shares the board's seven-segment/LED display path between four requesters (CPU MMIO display register, test-case status, switch echo, error/trap reporter). It sits directly in front of the `displays` driver and produces its `data_display`, `led_display` and `blink_need` inputs. Selection is round-robin, and each grant is held for a guaranteed minimum dwell time so a value stays readable by a human. An optional urgent preemption lets requester 3 (error) seize the display at once.

## Interface
- `DWELL_CYCLES`, default 100_000_000: minimum grant duration in `clk` cycles (1 s at 100 MHz); must be ≥2.
- `IDLE_DATA`, default 24'd0: value driven on `data_display` when no grant is active.

- `clk`  in  1: 100 MHz system clock; all state is updated on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  4: level request per requester; bit 3 is the error requester.
- `data_in`  in  96: requester i's decimal value is `data_in[24*i +: 24]`.
- `led_in`  in  64: requester i's LED pattern is `led_in[16*i +: 16]`.
- `blink_in`  in  4: requester i's blink request.
- `grant`  out  4: one-hot grant, or all-zero when idle; registered.
- `data_display`  out  24: to the display driver; registered.
- `led_display`  out  16: to the display driver; registered.
- `blink_need`  out  1: to the display driver; registered.

## Operation
- The block has three states: IDLE, SHOW and HOLD.
- **IDLE:**
  - `grant`=0, `data_display`=IDLE_DATA, `led_display`=0, `blink_need`=0.
  - If any `req` is set, grant the arbitration winner and go to SHOW, clearing the dwell counter.
- **SHOW:**
  - Each cycle, the outputs copy the granted requester's live `data_in`/`led_in`/`blink_in`.
  - The dwell counter increments and saturates at DWELL_CYCLES-1.
  - If the granted `req` drops before the dwell expires, the outputs freeze at their last values and the state moves to HOLD.
- **HOLD:**
  - The outputs stay frozen and the counter keeps running. `grant` stays asserted, which tells the owner its frame is still visible.
- **Dwell expired** (counter == DWELL_CYCLES-1), in SHOW or HOLD:
  - If another requester is pending, re-arbitrate, grant the winner, clear the counter and enter SHOW.
  - Else if the current owner still requests while in SHOW, stay in SHOW.
  - Else go to IDLE.
- **Arbitration** is round-robin. The search starts at the index after the last granted requester (pointer `last`, reset to 3, so requester 0 wins first) and wraps 3→0. `last` updates on every new grant.
- A requester re-requesting during HOLD is treated as pending and competes normally.
- The dwell counter is $clog2(DWELL_CYCLES) bits wide and never wraps.

## Timing
- A request sampled at edge N produces `grant` and the new outputs at edge N+1: one cycle of latency from IDLE.
- All outputs are registered and change only on a `clk` edge.
- The dwell is counted from the grant edge. The earliest handover is DWELL_CYCLES cycles after the grant.
- Reset mid-operation forces the IDLE values immediately (asynchronously), clears the counter and sets `last`=3.
- Simultaneous requests in IDLE are resolved by the round-robin order alone.

## Configuration
- **With `DISP_ARB_PREEMPT_EN` defined:**
  - A rising `req[3]` while another requester owns the display (SHOW or HOLD) takes the grant at the next edge, ignoring the remaining dwell.
  - The counter is cleared and `last` is set to 3.
  - `req[3]` also wins every arbitration regardless of `last`.
  - Requester 3 itself can never be preempted.
- **Without the macro:** requester 3 is an ordinary round-robin participant and the dwell is always honoured.

## Test plan
- **Reset/idle:** `rst_n`=0 for 3 cycles, then no requests → `grant`=0, `data_display`=0, `led_display`=0, `blink_need`=0. An asynchronous reset asserted during SHOW clears all outputs within the same cycle.
- **Single grant:** DWELL_CYCLES=8, `req`=4'b0010 with `data_in[47:24]`=123456.
  - One cycle later, `grant`=4'b0010 and `data_display`=123456.
  - Changing the input to 654321 is followed on the next edge.
  - Dropping `req` at cycle 3 freezes 654321 until cycle 8, then the block returns to IDLE.
- **Round-robin:** all four `req` held with DWELL_CYCLES=8 → the grant sequence is 0,1,2,3,0, each held exactly 8 cycles.
- **Hold without competition:** `req[2]` held alone for 40 cycles → `grant` stays 4'b0100 with no IDLE gap.
- **Preemption:** with `DISP_ARB_PREEMPT_EN`, requester 0 granted, then `req[3]` rises at dwell cycle 2 → `grant`=4'b1000 on the next edge and `blink_need` follows `blink_in[3]`. Without the macro, requester 3 is granted only after cycle 8.
- **Blink/LED pass-through:** owner `blink_in`=1 and `led_in`=16'hA5A5 → `blink_need`=1 and `led_display`=16'hA5A5; both clear on the return to IDLE.
